riscv_v_reduct_seq: RTL and testbench
=====================================

RISCV_V_REDUCT_SEQ -- requirements
Module: riscv_v_reduct_seq

Interface
REQ-001 Parameter DATA_WIDTH, default RISCV_V_DATA_WIDTH (128): vector operand width in bits; power of two, minimum 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_opcode  input  riscv_v_opcode_e  operation; only BW_AND_REDUCT, BW_OR_REDUCT and BW_XOR_REDUCT are legal.
REQ-007 in_osize  input  riscv_v_osize_e  element size (OSIZE_8..OSIZE_128).
REQ-008 in_src  input  DATA_WIDTH  source vector.
REQ-009 in_byte_valid  input  DATA_WIDTH/8  per-byte valid mask.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_result  output  DATA_WIDTH  reduced element in bits [E-1:0], where E is the element width; upper bits zero.
REQ-013 out_err  output  1  request was illegal; qualified by out_valid.

Function
REQ-014 The block SHALL be an FSM with states IDLE, REDUCE and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-016 On acceptance the block SHALL latch in_src into an accumulator ACC, latch the opcode, and load a counter with N = log2(DATA_WIDTH/E).
REQ-017 If N>0, the next state SHALL be REDUCE; if N=0, the next state SHALL be DONE with out_result = ACC.
REQ-018 Each REDUCE cycle SHALL fold the accumulator: ACC[W/2-1:0] <= ACC[W/2-1:0] op ACC[W-1:W/2], where W is the current active width (DATA_WIDTH on entry, halved on each fold); upper bits are cleared.
REQ-019 After each fold the counter SHALL decrement; the fold that takes the counter from 1 to 0 SHALL move the state to DONE.
REQ-020 out_valid SHALL rise exactly N+1 cycles after the accepting edge. For example, DATA_WIDTH=128 with OSIZE_8 gives 5 cycles.
REQ-021 In DONE, out_valid=1 and out_result/out_err SHALL be held stable until out_ready=1.
REQ-022 A DONE cycle with out_ready=1 SHALL return the FSM to IDLE. A new request cannot be accepted in that same cycle.
REQ-023 A request is illegal if the opcode is not a REDUCT opcode, or E>DATA_WIDTH, or in_osize is an encoding above OSIZE_128.
REQ-024 An illegal request SHALL be accepted normally and go directly to DONE with out_err=1 and out_result=0.
REQ-025 in_valid while not in IDLE SHALL be ignored. A requester SHALL hold in_valid and its fields stable until it is accepted.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, ACC=0, counter=0, out_valid=0, out_err=0, out_result=0; in_ready SHALL be 1 once rst_n=1.
REQ-027 Reset during REDUCE or DONE SHALL discard the operation in flight; no result is produced.

Configuration
REQ-028 Macro RISCV_V_REDUCT_MASK_EN, when defined, SHALL replace every byte with in_byte_valid=0 by the identity byte at acceptance: 0xFF for AND, 0x00 for OR and XOR.
REQ-029 Without RISCV_V_REDUCT_MASK_EN, the in_byte_valid port SHALL remain present but be ignored, and all bytes SHALL participate.

Structure
REQ-030 riscv_v_pkg SHALL hold a reduct FSM state enum and a function f_osize_to_width(riscv_v_osize_e) that returns E in bits.
REQ-031 The one natural sub-module is riscv_v_reduct_fold: a combinational single fold step taking operand, active width and opcode.

Verification
REQ-032 DATA_WIDTH=128, XOR_REDUCT, OSIZE_8, bytes 0x01..0x10 (byte0=0x01) -> out_result=0x10, out_err=0, out_valid 5 cycles after accept.
REQ-033 AND_REDUCT, OSIZE_32, dwords {0xFFFFFFFF, 0x0000FFFF, 0xFFFFFFFF, 0xFFFFFFFF} -> out_result=0x0000FFFF, out_valid 3 cycles after accept.
REQ-034 OR_REDUCT, OSIZE_128, in_src=0x1234 -> out_result=0x1234 one cycle after accept; then out_ready=0 for 3 cycles -> result stable, in_ready=0.
REQ-035 AND_REDUCT, OSIZE_8, byte0=0xA5, other bytes 0x00, in_byte_valid=0x0001 -> out_result=0xA5 with the macro, 0x00 without it.
REQ-036 Opcode SLL -> out_err=1, out_result=0 one cycle after accept. Separately, rst_n pulsed low during REDUCE -> no out_valid, and in_ready=1 after release.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector reduction sequencer: opcodes,
// element sizes, reduction FSM states and element-width decoding.
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH = 128;

    typedef enum logic [3:0] {
        VADD          = 4'd0,
        VSUB          = 4'd1,
        SLL           = 4'd2,
        SRL           = 4'd3,
        SRA           = 4'd4,
        BW_AND        = 4'd5,
        BW_OR         = 4'd6,
        BW_XOR        = 4'd7,
        BW_AND_REDUCT = 4'd8,
        BW_OR_REDUCT  = 4'd9,
        BW_XOR_REDUCT = 4'd10
    } riscv_v_opcode_e;

    typedef enum logic [2:0] {
        OSIZE_8   = 3'd0,
        OSIZE_16  = 3'd1,
        OSIZE_32  = 3'd2,
        OSIZE_64  = 3'd3,
        OSIZE_128 = 3'd4
    } riscv_v_osize_e;

    typedef enum logic [1:0] {
        REDUCT_IDLE   = 2'd0,
        REDUCT_REDUCE = 2'd1,
        REDUCT_DONE   = 2'd2
    } riscv_v_reduct_state_e;

    // Encodings above OSIZE_128 decode to 0 so callers can flag them as illegal.
    function automatic int f_osize_to_width(riscv_v_osize_e osize);
        case (osize)
            OSIZE_8:   return 8;
            OSIZE_16:  return 16;
            OSIZE_32:  return 32;
            OSIZE_64:  return 64;
            OSIZE_128: return 128;
            default:   return 0;
        endcase
    endfunction

    function automatic logic f_is_reduct(riscv_v_opcode_e op);
        return (op == BW_AND_REDUCT) || (op == BW_OR_REDUCT) || (op == BW_XOR_REDUCT);
    endfunction

endpackage

// File: rtl/riscv_v_reduct_seq_if.sv
// Request/response bundle of the reduction sequencer; slave is the block side.
interface riscv_v_reduct_seq_if
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    riscv_v_opcode_e           in_opcode;
    riscv_v_osize_e            in_osize;
    logic [DATA_WIDTH-1:0]     in_src;
    logic [DATA_WIDTH/8-1:0]   in_byte_valid;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic                      out_err;

    modport master (
        output in_valid, in_opcode, in_osize, in_src, in_byte_valid, out_ready,
        input  in_ready, out_valid, out_result, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_osize, in_src, in_byte_valid, out_ready,
        output in_ready, out_valid, out_result, out_err
    );
endinterface

// File: rtl/riscv_v_reduct_fold.sv
// One combinational fold step: low half of the active width combined with
// the high half; everything above the new half-width is cleared.
module riscv_v_reduct_fold
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int WW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [WW-1:0]         width_i,
    input  riscv_v_opcode_e       opcode_i,
    output logic [DATA_WIDTH-1:0] fold_o
);
    logic [WW-1:0]         half;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] keep;

    assign half = width_i >> 1;
    assign hi   = acc_i >> half;
    assign keep = ~({DATA_WIDTH{1'b1}} << half);

    always_comb begin
        fold_o = '0;
        case (opcode_i)
            BW_AND_REDUCT: fold_o = (acc_i & hi) & keep;
            BW_OR_REDUCT:  fold_o = (acc_i | hi) & keep;
            BW_XOR_REDUCT: fold_o = (acc_i ^ hi) & keep;
            default:       fold_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Sequential AND/OR/XOR vector reduction, one halving fold per cycle.
// Optional RISCV_V_REDUCT_MASK_EN substitutes identity bytes for masked-off bytes.
module riscv_v_reduct_seq
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    riscv_v_reduct_seq_if.slave bus
);
    localparam int LOG2_DW = $clog2(DATA_WIDTH);
    localparam int WW      = LOG2_DW + 1;
    localparam int CW      = (LOG2_DW > 1) ? LOG2_DW : 1;

    riscv_v_reduct_state_e state_q;
    riscv_v_opcode_e       op_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [WW-1:0]         width_q;
    logic [CW-1:0]         cnt_q;
    logic                  out_valid_q;
    logic                  out_err_q;
    logic                  in_ready_q;

    logic [DATA_WIDTH-1:0] src_d;
    logic [DATA_WIDTH-1:0] fold_d;
    logic [CW-1:0]         cnt_d;
    logic                  legal_d;
    int                    elem_w;
    int                    n_full;

    always_comb begin
        src_d = bus.in_src;
`ifdef RISCV_V_REDUCT_MASK_EN
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (!bus.in_byte_valid[b]) begin
                src_d[b*8 +: 8] = (bus.in_opcode == BW_AND_REDUCT) ? 8'hFF : 8'h00;
            end
        end
`endif
    end

`ifndef RISCV_V_REDUCT_MASK_EN
    logic unused_byte_valid;
    assign unused_byte_valid = ^bus.in_byte_valid;
`endif

    // Element width is 8 << osize, so the fold count is log2(DATA_WIDTH) - (osize + 3).
    always_comb begin
        elem_w  = f_osize_to_width(bus.in_osize);
        legal_d = f_is_reduct(bus.in_opcode) && (elem_w != 0) && (elem_w <= DATA_WIDTH);
        n_full  = LOG2_DW - (int'(bus.in_osize) + 3);
        cnt_d   = legal_d ? CW'(n_full) : '0;
    end

    riscv_v_reduct_fold #(
        .DATA_WIDTH (DATA_WIDTH),
        .WW         (WW)
    ) u_fold (
        .acc_i    (acc_q),
        .width_i  (width_q),
        .opcode_i (op_q),
        .fold_o   (fold_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REDUCT_IDLE;
            op_q        <= BW_AND_REDUCT;
            acc_q       <= '0;
            result_q    <= '0;
            width_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                REDUCT_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        op_q       <= bus.in_opcode;
                        acc_q      <= src_d;
                        width_q    <= WW'(DATA_WIDTH);
                        cnt_q      <= cnt_d;
                        if (!legal_d) begin
                            state_q     <= REDUCT_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            result_q    <= '0;
                        end else if (cnt_d == '0) begin
                            state_q     <= REDUCT_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            result_q    <= src_d;
                        end else begin
                            state_q <= REDUCT_REDUCE;
                        end
                    end
                end
                REDUCT_REDUCE: begin
                    acc_q   <= fold_d;
                    width_q <= width_q >> 1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= REDUCT_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        result_q    <= fold_d;
                    end
                end
                REDUCT_DONE: begin
                    // Result registers are left untouched so they stay stable while stalled.
                    if (bus.out_ready) begin
                        state_q     <= REDUCT_IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= REDUCT_IDLE;
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_result = result_q;

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Scoreboard bench for riscv_v_reduct_seq at DATA_WIDTH=128; honours RISCV_V_REDUCT_MASK_EN.
module tb_riscv_v_reduct_seq;
    import riscv_v_pkg::*;

    localparam int DW = 128;

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int            lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    riscv_v_reduct_seq_if #(.DATA_WIDTH(DW)) bus ();

    riscv_v_reduct_seq #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: reduce every element of the (optionally masked) source directly.
    function automatic exp_t model(riscv_v_opcode_e op, riscv_v_osize_e os,
                                   logic [DW-1:0] src, logic [DW/8-1:0] bv);
        exp_t          e;
        int            w;
        logic          legal;
        logic [DW-1:0] s, m, acc, elem;
        w     = (int'(os) <= 4) ? (8 << int'(os)) : 0;
        legal = (op == BW_AND_REDUCT || op == BW_OR_REDUCT || op == BW_XOR_REDUCT)
                && (w != 0) && (w <= DW);
        if (!legal) begin
            e.res = '0;
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        s = src;
`ifdef RISCV_V_REDUCT_MASK_EN
        for (int b = 0; b < DW/8; b++)
            if (!bv[b]) s[b*8 +: 8] = (op == BW_AND_REDUCT) ? 8'hFF : 8'h00;
`else
        if (bv == '1) s = src;
`endif
        m   = (w == DW) ? '1 : ((DW'(1) << w) - 1);
        acc = s & m;
        for (int k = 1; k < DW/w; k++) begin
            elem = (s >> (k*w)) & m;
            case (op)
                BW_AND_REDUCT: acc = acc & elem;
                BW_OR_REDUCT:  acc = acc | elem;
                default:       acc = acc ^ elem;
            endcase
        end
        e.res = acc;
        e.err = 1'b0;
        e.lat = 1;
        for (int x = w; x < DW; x = x * 2) e.lat++;
        return e;
    endfunction

    // Called at posedge+1: drive, wait for accept, wait for result, compare, drain.
    task automatic run_req(input string tag, input riscv_v_opcode_e op, input riscv_v_osize_e os,
                           input logic [DW-1:0] src, input logic [DW/8-1:0] bv, input int hold);
        exp_t e;
        int   cyc;
        int   lat;
        sb.push_back(model(op, os, src, bv));
        bus.in_opcode     = op;
        bus.in_osize      = os;
        bus.in_src        = src;
        bus.in_byte_valid = bv;
        bus.in_valid      = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 50) chk({tag, "_accept_timeout"}, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_result"}, bus.out_result, e.res);
        chk({tag, "_err"}, bus.out_err, e.err);
        chk({tag, "_latency"}, DW'(lat), DW'(e.lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, "_hold_result"}, bus.out_result, e.res);
            chk({tag, "_hold_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drain_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_drain_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [DW-1:0]   src;
        riscv_v_opcode_e ops [3];
        int              seen;
        ops = '{BW_AND_REDUCT, BW_OR_REDUCT, BW_XOR_REDUCT};
        n_checks          = 0;
        n_errors          = 0;
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_opcode     = BW_AND_REDUCT;
        bus.in_osize      = OSIZE_8;
        bus.in_src        = '0;
        bus.in_byte_valid = '1;
        bus.out_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_out_result", bus.out_result, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 16; i++) src[i*8 +: 8] = 8'(i + 1);
        run_req("xor8", BW_XOR_REDUCT, OSIZE_8, src, '1, 0);
        chk("xor8_known", DW'(8'h10), model(BW_XOR_REDUCT, OSIZE_8, src, '1).res);

        src = {32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_req("and32", BW_AND_REDUCT, OSIZE_32, src, '1, 1);

        run_req("or128", BW_OR_REDUCT, OSIZE_128, DW'(16'h1234), '1, 3);

        src = DW'(8'hA5);
        run_req("mask_and8", BW_AND_REDUCT, OSIZE_8, src, 16'h0001, 0);

        run_req("ill_sll", SLL, OSIZE_8, {4{32'hDEADBEEF}}, '1, 1);
        run_req("ill_osize", BW_OR_REDUCT, riscv_v_osize_e'(3'd5), {4{32'h0F0F0F0F}}, '1, 0);

        src = {32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
        run_req("or16", BW_OR_REDUCT, OSIZE_16, src, '1, 0);
        src = {64'h8000_0000_0000_0001, 64'h0000_0000_0000_00FF};
        run_req("xor64", BW_XOR_REDUCT, OSIZE_64, src, 16'hFF0F, 2);

        for (int t = 0; t < 10; t++) begin
            src = {$urandom, $urandom, $urandom, $urandom};
            if (t % 3 == 0) src = src | {$urandom, $urandom, $urandom, $urandom};
            run_req("rand", ops[$urandom_range(0, 2)], riscv_v_osize_e'(3'($urandom_range(0, 4))),
                    src, 16'($urandom), $urandom_range(0, 2));
        end

        // Reset pulsed while folding must discard the operation.
        bus.in_opcode     = BW_XOR_REDUCT;
        bus.in_osize      = OSIZE_8;
        bus.in_src        = {4{32'h12345678}};
        bus.in_byte_valid = '1;
        bus.in_valid      = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_busy", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("rstmid_valid_low", bus.out_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_in_ready", bus.in_ready, 1'b1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rstmid_no_result", DW'(seen), '0);

        run_req("post_rst", BW_AND_REDUCT, OSIZE_16, {8{16'hF0FF}}, '1, 0);

        chk("sb_empty", DW'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
